// File: rtl/gpu_csr_pkg.sv
// Shared types and constants for the gpu_csr register file.
//   vec3_t / camera_t : camera description handed to gpu_controller
//   CSR_*             : slave word addresses
//   CTRL_* / STATUS_* : bit positions inside CTRL and STATUS
//   csr_state_e       : launch/complete handshake states
package gpu_csr_pkg;

  localparam int unsigned CSR_DATA_BITS = 32;
  localparam int unsigned CSR_ADDR_BITS = 5;
  localparam int unsigned NUM_STAGE     = 20;  // 5 render args + 15 camera words

  typedef struct packed {
    logic [CSR_DATA_BITS-1:0] x;
    logic [CSR_DATA_BITS-1:0] y;
    logic [CSR_DATA_BITS-1:0] z;
  } vec3_t;

  typedef struct packed {
    vec3_t pos;
    vec3_t look0;
    vec3_t look1;
    vec3_t look2;
    vec3_t look3;
  } camera_t;

  localparam logic [CSR_ADDR_BITS-1:0] CSR_CTRL           = 5'd0;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_STATUS         = 5'd1;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_PIXEL_BUFFER   = 5'd2;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_VOXEL_BUFFER   = 5'd3;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_VOXEL_COUNT    = 5'd4;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_PALETTE_BUFFER = 5'd5;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_PALETTE_LENGTH = 5'd6;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_FRAME_COUNT    = 5'd7;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_CAM_POS_X      = 5'd8;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_CAM_LOOK3_Z    = 5'd22;

  localparam int unsigned CTRL_START     = 0;
  localparam int unsigned CTRL_IRQ_CLEAR = 1;
  localparam int unsigned CTRL_IRQ_EN    = 2;
  localparam int unsigned CTRL_ERR_CLEAR = 3;

  localparam int unsigned STATUS_BUSY        = 0;
  localparam int unsigned STATUS_IRQ_PENDING = 1;
  localparam int unsigned STATUS_IRQ_EN      = 2;
  localparam int unsigned STATUS_ERR         = 3;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StBusy,
    StDone,
    StAck,
    StDrain
  } csr_state_e;

  function automatic logic is_staging(input logic [CSR_ADDR_BITS-1:0] a);
    return ((a >= CSR_PIXEL_BUFFER) && (a <= CSR_PALETTE_LENGTH)) ||
           ((a >= CSR_CAM_POS_X) && (a <= CSR_CAM_LOOK3_Z));
  endfunction

  // Packs the two staging address ranges into a dense 0..19 index
  // (FRAME_COUNT at address 7 sits between them).
  function automatic logic [4:0] stage_idx(input logic [CSR_ADDR_BITS-1:0] a);
    if (a <= CSR_PALETTE_LENGTH) return a - 5'd2;
    return a - 5'd3;
  endfunction

endpackage

// File: rtl/gpu_csr_bank.sv
// Staging and active register arrays for gpu_csr.
//   wr_en/wr_idx/wr_data/wr_be : byte-enabled write into one staging word
//   snapshot                   : copy every staging word into active
//   stage / active             : full contents of both arrays
module gpu_csr_bank
  import gpu_csr_pkg::*;
#(
  parameter int unsigned NUM_REGS  = NUM_STAGE,
  parameter int unsigned DATA_BITS = CSR_DATA_BITS
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               wr_en,
  input  logic [4:0]                         wr_idx,
  input  logic [DATA_BITS-1:0]               wr_data,
  input  logic [DATA_BITS/8-1:0]             wr_be,
  input  logic                               snapshot,
  output logic [NUM_REGS-1:0][DATA_BITS-1:0] stage,
  output logic [NUM_REGS-1:0][DATA_BITS-1:0] active
);

  logic [NUM_REGS-1:0][DATA_BITS-1:0] stage_q;
  logic [NUM_REGS-1:0][DATA_BITS-1:0] active_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_q  <= '0;
      active_q <= '0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < DATA_BITS / 8; b++) begin
          if (wr_be[b]) stage_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
      // Snapshot takes the pre-edge staging values; a launch is a CTRL write,
      // so it never coincides with a staging write.
      if (snapshot) active_q <= stage_q;
    end
  end

  assign stage  = stage_q;
  assign active = active_q;

endmodule

// File: rtl/gpu_csr.sv
// Avalon-MM register file that stages render arguments, freezes them on
// launch and runs the do_render / irq / clear_interrupt handshake with
// gpu_controller.
//   clock, reset_n         : clock, asynchronous active-low reset
//   s1_*                   : Avalon-MM slave, single-cycle write, read latency 1
//   cam, pixel_buffer, ... : active (frozen) render arguments
//   do_render              : one-cycle launch pulse
//   gpu_irq                : completion level from gpu_controller
//   clear_interrupt        : one-cycle completion acknowledge
//   irq                    : host interrupt, pending & enabled
module gpu_csr
  import gpu_csr_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned DATA_BITS = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [ADDR_BITS-1:0]   s1_address,
  input  logic                   s1_read,
  input  logic                   s1_write,
  input  logic [DATA_BITS-1:0]   s1_writedata,
  input  logic [DATA_BITS/8-1:0] s1_byteenable,
  output logic [DATA_BITS-1:0]   s1_readdata,
  output camera_t                cam,
  output logic [DATA_BITS-1:0]   pixel_buffer,
  output logic [DATA_BITS-1:0]   voxel_buffer,
  output logic [DATA_BITS-1:0]   voxel_count,
  output logic [DATA_BITS-1:0]   palette_buffer,
  output logic [DATA_BITS-1:0]   palette_length,
  output logic                   do_render,
  output logic                   clear_interrupt,
  input  logic                   gpu_irq,
  output logic                   irq
);

  logic [CSR_ADDR_BITS-1:0] addr;
  assign addr = s1_address[CSR_ADDR_BITS-1:0];

  csr_state_e             state_q;
  logic                   irq_en_q;
  logic                   err_q;
  logic                   irq_pending_q;
  logic [DATA_BITS-1:0]   frame_count_q;
  logic                   do_render_q;
  logic                   clear_interrupt_q;
  logic [DATA_BITS-1:0]   readdata_q;
  logic [DATA_BITS-1:0]   readdata_d;

  logic [NUM_STAGE-1:0][DATA_BITS-1:0] stage;
  logic [NUM_STAGE-1:0][DATA_BITS-1:0] active;

  logic ctrl_wr, start, irq_clear, err_clear, snapshot;

  assign ctrl_wr   = s1_write && (addr == CSR_CTRL);
  assign start     = ctrl_wr && s1_writedata[CTRL_START];
  assign irq_clear = ctrl_wr && s1_writedata[CTRL_IRQ_CLEAR];
  assign err_clear = ctrl_wr && s1_writedata[CTRL_ERR_CLEAR];
  assign snapshot  = start && (state_q == StIdle);

  gpu_csr_bank #(
    .NUM_REGS  (NUM_STAGE),
    .DATA_BITS (DATA_BITS)
  ) u_bank (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_en    (s1_write && is_staging(addr)),
    .wr_idx   (stage_idx(addr)),
    .wr_data  (s1_writedata),
    .wr_be    (s1_byteenable),
    .snapshot (snapshot),
    .stage    (stage),
    .active   (active)
  );

  // Handshake FSM; pulses are registered so they line up with the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= StIdle;
      irq_en_q          <= 1'b0;
      err_q             <= 1'b0;
      irq_pending_q     <= 1'b0;
      frame_count_q     <= '0;
      do_render_q       <= 1'b0;
      clear_interrupt_q <= 1'b0;
    end else begin
      do_render_q       <= 1'b0;
      clear_interrupt_q <= 1'b0;
      if (ctrl_wr && s1_byteenable[0]) irq_en_q <= s1_writedata[CTRL_IRQ_EN];
      if (err_clear) err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StLaunch;
            do_render_q <= 1'b1;
          end
        end
        StLaunch: state_q <= StBusy;
        StBusy: begin
          if (gpu_irq) begin
            state_q       <= StDone;
            irq_pending_q <= 1'b1;
            frame_count_q <= frame_count_q + 1'b1;
          end
        end
        StDone: begin
          if (irq_clear) begin
            state_q           <= StAck;
            irq_pending_q     <= 1'b0;
            clear_interrupt_q <= 1'b1;
          end
        end
        StAck:   state_q <= StDrain;
        StDrain: if (!gpu_irq) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      // A rejected START wins over an ERR_CLEAR in the same write.
      if (start && (state_q != StIdle)) err_q <= 1'b1;
    end
  end

  always_comb begin
    readdata_d = '0;
    if (addr == CSR_CTRL) begin
      readdata_d[CTRL_IRQ_EN] = irq_en_q;
    end else if (addr == CSR_STATUS) begin
      readdata_d[STATUS_BUSY]        = (state_q == StLaunch) || (state_q == StBusy);
      readdata_d[STATUS_IRQ_PENDING] = irq_pending_q;
      readdata_d[STATUS_IRQ_EN]      = irq_en_q;
      readdata_d[STATUS_ERR]         = err_q;
    end else if (addr == CSR_FRAME_COUNT) begin
      readdata_d = frame_count_q;
    end else if (is_staging(addr)) begin
      readdata_d = stage[stage_idx(addr)];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else if (s1_read) readdata_q <= readdata_d;
  end

  assign s1_readdata     = readdata_q;
  assign do_render       = do_render_q;
  assign clear_interrupt = clear_interrupt_q;
  assign irq             = irq_pending_q & irq_en_q;

  assign pixel_buffer   = active[0];
  assign voxel_buffer   = active[1];
  assign voxel_count    = active[2];
  assign palette_buffer = active[3];
  assign palette_length = active[4];
  assign cam.pos.x      = active[5];
  assign cam.pos.y      = active[6];
  assign cam.pos.z      = active[7];
  assign cam.look0.x    = active[8];
  assign cam.look0.y    = active[9];
  assign cam.look0.z    = active[10];
  assign cam.look1.x    = active[11];
  assign cam.look1.y    = active[12];
  assign cam.look1.z    = active[13];
  assign cam.look2.x    = active[14];
  assign cam.look2.y    = active[15];
  assign cam.look2.z    = active[16];
  assign cam.look3.x    = active[17];
  assign cam.look3.y    = active[18];
  assign cam.look3.z    = active[19];

endmodule

// File: tb/tb_gpu_csr.sv
// Self-checking bench for gpu_csr: directed handshake steps plus random
// staging writes checked against an address-indexed memory model.
module tb_gpu_csr;
  import gpu_csr_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  s1_address = '0;
  logic        s1_read = 1'b0;
  logic        s1_write = 1'b0;
  logic [31:0] s1_writedata = '0;
  logic [3:0]  s1_byteenable = '0;
  logic [31:0] s1_readdata;
  camera_t     cam;
  logic [31:0] pixel_buffer, voxel_buffer, voxel_count, palette_buffer, palette_length;
  logic        do_render, clear_interrupt, irq;
  logic        gpu_irq = 1'b0;

  int checks = 0;
  int failures = 0;

  // Model: staging/active memories indexed by register address.
  logic [31:0] stage_m  [32];
  logic [31:0] active_m [32];
  logic [31:0] frame_m;
  logic [31:0] rd_val;

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  gpu_csr dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .s1_address      (s1_address),
    .s1_read         (s1_read),
    .s1_write        (s1_write),
    .s1_writedata    (s1_writedata),
    .s1_byteenable   (s1_byteenable),
    .s1_readdata     (s1_readdata),
    .cam             (cam),
    .pixel_buffer    (pixel_buffer),
    .voxel_buffer    (voxel_buffer),
    .voxel_count     (voxel_count),
    .palette_buffer  (palette_buffer),
    .palette_length  (palette_length),
    .do_render       (do_render),
    .clear_interrupt (clear_interrupt),
    .gpu_irq         (gpu_irq),
    .irq             (irq)
  );

  function automatic bit is_stage(input int a);
    return (a >= 2 && a <= 6) || (a >= 8 && a <= 22);
  endfunction

  // Expected read for every address except CTRL/STATUS.
  function automatic logic [31:0] exp_rd(input int a);
    if (is_stage(a)) return stage_m[a];
    if (a == 7) return frame_m;
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All bus tasks enter and leave at a falling edge.
  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    s1_write = 1'b1;
    s1_address = a[4:0];
    s1_writedata = d;
    s1_byteenable = be;
    @(negedge clock);
    s1_write = 1'b0;
    s1_byteenable = '0;
    if (is_stage(a)) begin
      for (int b = 0; b < 4; b++) if (be[b]) stage_m[a][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    s1_read = 1'b1;
    s1_address = a[4:0];
    @(negedge clock);
    s1_read = 1'b0;
    d = s1_readdata;
  endtask

  task automatic chk_rd(input string tag, input int a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic launch_model();
    for (int a = 0; a < 32; a++) active_m[a] = stage_m[a];
  endtask

  task automatic clear_model();
    for (int a = 0; a < 32; a++) begin
      stage_m[a] = '0;
      active_m[a] = '0;
    end
    frame_m = '0;
  endtask

  task automatic chk_active();
    chk("act_pixel_buffer", pixel_buffer, active_m[2]);
    chk("act_voxel_buffer", voxel_buffer, active_m[3]);
    chk("act_voxel_count", voxel_count, active_m[4]);
    chk("act_palette_buffer", palette_buffer, active_m[5]);
    chk("act_palette_length", palette_length, active_m[6]);
    chk("act_pos_x", cam.pos.x, active_m[8]);
    chk("act_pos_y", cam.pos.y, active_m[9]);
    chk("act_pos_z", cam.pos.z, active_m[10]);
    chk("act_look0_x", cam.look0.x, active_m[11]);
    chk("act_look0_y", cam.look0.y, active_m[12]);
    chk("act_look0_z", cam.look0.z, active_m[13]);
    chk("act_look1_x", cam.look1.x, active_m[14]);
    chk("act_look1_y", cam.look1.y, active_m[15]);
    chk("act_look1_z", cam.look1.z, active_m[16]);
    chk("act_look2_x", cam.look2.x, active_m[17]);
    chk("act_look2_y", cam.look2.y, active_m[18]);
    chk("act_look2_z", cam.look2.z, active_m[19]);
    chk("act_look3_x", cam.look3.x, active_m[20]);
    chk("act_look3_y", cam.look3.y, active_m[21]);
    chk("act_look3_z", cam.look3.z, active_m[22]);
  endtask

  initial begin
    clear_model();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Reset state
    chk("rst_do_render", {31'b0, do_render}, 32'h0);
    chk("rst_clear_interrupt", {31'b0, clear_interrupt}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 32; a++) chk_rd("rst_read", a, 32'h0);
    chk_active();

    // Byte-enabled staging write stays out of the active copy
    wr(4, 32'h0000_0100, 4'b0010);
    chk_rd("vc_stage", 4, 32'h0000_0100);
    chk("vc_active_hold", voxel_count, 32'h0);

    // IRQ_EN, then launch
    wr(0, 32'h4, 4'hF);
    chk_rd("ctrl_irq_en", 0, 32'h4);
    wr(0, 32'h5, 4'hF);
    launch_model();
    chk("launch_do_render", {31'b0, do_render}, 32'h1);
    chk("launch_voxel_count", voxel_count, 32'h0000_0100);
    @(negedge clock);
    chk("launch_pulse_end", {31'b0, do_render}, 32'h0);
    chk_rd("status_busy", 1, 32'h5);

    // Random staging writes mid-render: readable, active frozen
    for (int i = 0; i < 40; i++) begin
      int a;
      a = int'($urandom_range(31, 1));
      wr(a, $urandom, 4'($urandom));
    end
    chk_active();
    for (int a = 2; a < 32; a++) chk_rd("rand_read", a, exp_rd(a));

    // START while busy is rejected and flags err
    wr(8, 32'h1234, 4'hF);
    wr(0, 32'h5, 4'hF);
    chk("busy_start_no_pulse", {31'b0, do_render}, 32'h0);
    chk("busy_pos_x_hold", cam.pos.x, active_m[8]);
    chk_rd("status_err", 1, 32'hD);
    wr(0, 32'hC, 4'hF);
    chk_rd("status_err_clr", 1, 32'h5);
    repeat (40) @(negedge clock);
    chk("busy_no_pulse", {31'b0, do_render}, 32'h0);

    // Completion
    gpu_irq = 1'b1;
    @(negedge clock);
    frame_m = frame_m + 1;
    chk("done_irq", {31'b0, irq}, 32'h1);
    chk_rd("status_done", 1, 32'h6);
    chk_rd("frame_one", 7, frame_m);
    wr(0, 32'h0, 4'hF);
    chk("mask_irq", {31'b0, irq}, 32'h0);
    chk_rd("status_masked", 1, 32'h2);
    wr(0, 32'h4, 4'hF);
    chk("unmask_irq", {31'b0, irq}, 32'h1);
    wr(0, 32'h6, 4'hF);
    chk("ack_clear_int", {31'b0, clear_interrupt}, 32'h1);
    chk("ack_irq_low", {31'b0, irq}, 32'h0);
    @(negedge clock);
    chk("ack_pulse_end", {31'b0, clear_interrupt}, 32'h0);
    chk_rd("status_drain", 1, 32'h4);
    gpu_irq = 1'b0;
    @(negedge clock);
    chk_rd("status_idle", 1, 32'h4);

    // START with IRQ_CLEAR in idle launches; random staging goes active
    wr(0, 32'h7, 4'hF);
    launch_model();
    chk("idle_start_clr_pulse", {31'b0, do_render}, 32'h1);
    @(negedge clock);
    chk_active();
    chk_rd("status_no_err", 1, 32'h5);

    // FRAME_COUNT wrap via backdoor
    force dut.frame_count_q = 32'hFFFF_FFFF;
    @(negedge clock);
    release dut.frame_count_q;
    frame_m = 32'hFFFF_FFFF;
    chk_rd("frame_preset", 7, frame_m);
    gpu_irq = 1'b1;
    @(negedge clock);
    frame_m = frame_m + 1;
    chk_rd("frame_wrap", 7, frame_m);

    // START with IRQ_CLEAR in DONE: clear taken, START rejected
    wr(0, 32'h7, 4'hF);
    chk("done_start_clr_ack", {31'b0, clear_interrupt}, 32'h1);
    chk("done_start_no_pulse", {31'b0, do_render}, 32'h0);
    chk_rd("status_done_err", 1, 32'hC);
    gpu_irq = 1'b0;
    @(negedge clock);
    wr(0, 32'hC, 4'hF);
    chk_rd("status_err_clr2", 1, 32'h4);

    // Reset while busy
    wr(0, 32'h5, 4'hF);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    clear_model();
    chk("mid_rst_do_render", {31'b0, do_render}, 32'h0);
    chk("mid_rst_clear_int", {31'b0, clear_interrupt}, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    chk("mid_rst_readdata", s1_readdata, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_exit_no_pulse", {31'b0, do_render}, 32'h0);
    chk_active();
    chk_rd("mid_rst_ctrl", 0, 32'h0);
    chk_rd("mid_rst_status", 1, 32'h0);
    for (int a = 2; a < 32; a++) chk_rd("mid_rst_read", a, exp_rd(a));

    // Normal launch after reset
    wr(4, 32'h55, 4'hF);
    wr(0, 32'h1, 4'hF);
    launch_model();
    chk("post_rst_pulse", {31'b0, do_render}, 32'h1);
    @(negedge clock);
    chk("post_rst_pulse_end", {31'b0, do_render}, 32'h0);
    chk("post_rst_voxel_count", voxel_count, active_m[4]);
    chk_rd("post_rst_status", 1, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
